// File: rtl/program_loader_pkg.sv
// -----------------------------------------------------------------------------
// program_loader_pkg
// Shared definitions for the program loader: host command bytes, reply bytes
// and the controller state encoding.
// -----------------------------------------------------------------------------
package program_loader_pkg;

   // Host command bytes (ASCII)
   localparam logic [7:0] CMD_LOAD = 8'h4C;   // 'L'
   localparam logic [7:0] CMD_RUN  = 8'h52;   // 'R'
   localparam logic [7:0] CMD_STEP = 8'h53;   // 'S'
   localparam logic [7:0] CMD_HALT = 8'h48;   // 'H'

   // Reply bytes
   localparam logic [7:0] ACK = 8'h06;
   localparam logic [7:0] NAK = 8'h15;

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      LOAD_CNT  = 3'd1,
      LOAD_WORD = 3'd2,
      WRITE     = 3'd3,
      RUN       = 3'd4,
      STEP      = 3'd5,
      RESP      = 3'd6
   } state_t;

endpackage

// File: rtl/program_loader_word_assembler.sv
// -----------------------------------------------------------------------------
// program_loader_word_assembler
// Collects four bytes, MSB first, into a 32-bit word. The completed word and
// the word_done strobe are presented combinationally in the same cycle as the
// fourth byte, so the caller can act on it at that clock edge.
//
// Ports:
//   clk        system clock
//   reset      synchronous reset, active-low
//   clear      synchronous clear of the byte counter and shift register
//   byte_valid byte_data is valid and should be consumed
//   byte_data  incoming byte
//   word       assembled word (valid when word_done=1)
//   word_done  fourth byte of a word is being consumed this cycle
// -----------------------------------------------------------------------------
module program_loader_word_assembler
   import program_loader_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        clear,
   input  logic        byte_valid,
   input  logic [7:0]  byte_data,
   output logic [31:0] word,
   output logic        word_done
);

   logic [23:0] shift;
   logic [1:0]  count;

   always_ff @(posedge clk) begin
      if (!reset || clear) begin
         shift <= 24'd0;
         count <= 2'd0;
      end else if (byte_valid) begin
         shift <= {shift[15:0], byte_data};
         count <= count + 2'd1;   // wraps 3 -> 0 at the end of each word
      end
   end

   assign word      = {shift, byte_data};
   assign word_done = byte_valid && (count == 2'd3);

endmodule

// File: rtl/program_loader.sv
// -----------------------------------------------------------------------------
// program_loader
// Host-side controller for the pipeline: decodes a UART command byte stream,
// loads instruction memory, runs / single-steps / halts the pipeline and
// returns one-byte status replies.
//
// Handshakes:
//   rx: i_rx_valid is a one-cycle strobe with no back-pressure. A byte arriving
//       while a reply is pending or during a memory write cycle is dropped and
//       flags o_rx_overrun (sticky until reset).
//   tx: o_tx_valid/o_tx_data are held stable until a cycle with i_tx_ready=1;
//       the byte is taken on that clock edge.
//
// Ports:
//   i_clk, i_reset                clock, synchronous active-low reset
//   i_rx_data, i_rx_valid         received byte and strobe
//   i_tx_ready                    transmitter can take a byte
//   i_program_end                 pipeline reached HALT (level)
//   o_tx_data, o_tx_valid         reply byte and valid
//   o_write_instruction_mem       one-cycle instruction-memory write strobe
//   o_instruction_mem_addr/_data  write byte address and word
//   o_halt                        1 = pipeline frozen
//   o_rx_overrun                  sticky dropped-byte flag
//   dbg_state                     current controller state
// -----------------------------------------------------------------------------
module program_loader
   import program_loader_pkg::*;
#(
   parameter int MEM_DEPTH = 256,
   parameter int ADDR_W    = 32
) (
   input  logic              i_clk,
   input  logic              i_reset,
   input  logic [7:0]        i_rx_data,
   input  logic              i_rx_valid,
   input  logic              i_tx_ready,
   input  logic              i_program_end,
   output logic [7:0]        o_tx_data,
   output logic              o_tx_valid,
   output logic              o_write_instruction_mem,
   output logic [ADDR_W-1:0] o_instruction_mem_addr,
   output logic [31:0]       o_instruction_mem_data,
   output logic              o_halt,
   output logic              o_rx_overrun,
   output state_t            dbg_state
);

   // One extra bit so that a count of exactly MEM_DEPTH is representable.
   localparam int IDX_W = $clog2(MEM_DEPTH) + 1;
   localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

   state_t           state;
   logic [IDX_W-1:0] word_idx;
   logic [IDX_W-1:0] word_count;
   logic [IDX_W-1:0] next_idx;
   logic             asm_valid;
   logic             asm_clear;
   logic             word_done;
   logic [31:0]      word;

   // Bytes feed the assembler only while a count or instruction word is being
   // collected; the assembler is held clear in IDLE so every load starts aligned.
   assign asm_valid = i_rx_valid && ((state == LOAD_CNT) || (state == LOAD_WORD));
   assign asm_clear = (state == IDLE);
   assign next_idx  = word_idx + IDX_ONE;
   assign dbg_state = state;

   program_loader_word_assembler u_word_assembler (
      .clk        (i_clk),
      .reset      (i_reset),
      .clear      (asm_clear),
      .byte_valid (asm_valid),
      .byte_data  (i_rx_data),
      .word       (word),
      .word_done  (word_done)
   );

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state                   <= IDLE;
         o_halt                  <= 1'b1;
         o_tx_valid              <= 1'b0;
         o_tx_data               <= 8'd0;
         o_write_instruction_mem <= 1'b0;
         o_instruction_mem_addr  <= '0;
         o_instruction_mem_data  <= 32'd0;
         o_rx_overrun            <= 1'b0;
         word_idx                <= '0;
         word_count              <= '0;
      end else begin
         o_write_instruction_mem <= 1'b0;

         if (i_rx_valid && ((state == RESP) || (state == WRITE)))
            o_rx_overrun <= 1'b1;

         case (state)
            IDLE: begin
               if (i_rx_valid) begin
                  case (i_rx_data)
                     CMD_LOAD: state <= LOAD_CNT;
                     CMD_RUN: begin
                        o_halt <= 1'b0;
                        state  <= RUN;
                     end
                     CMD_STEP: begin
                        if (i_program_end) begin
                           // Already at HALT: nothing to step, acknowledge at once.
                           o_tx_data  <= ACK;
                           o_tx_valid <= 1'b1;
                           state      <= RESP;
                        end else begin
                           o_halt <= 1'b0;
                           state  <= STEP;
                        end
                     end
                     CMD_HALT: begin
                        o_halt     <= 1'b1;
                        o_tx_data  <= ACK;
                        o_tx_valid <= 1'b1;
                        state      <= RESP;
                     end
                     default: begin
                        o_tx_data  <= NAK;
                        o_tx_valid <= 1'b1;
                        state      <= RESP;
                     end
                  endcase
               end
            end

            LOAD_CNT: begin
               if (word_done) begin
                  if (word == 32'd0) begin
                     o_tx_data  <= ACK;
                     o_tx_valid <= 1'b1;
                     state      <= RESP;
                  end else if (word > 32'(MEM_DEPTH)) begin
                     o_tx_data  <= NAK;
                     o_tx_valid <= 1'b1;
                     state      <= RESP;
                  end else begin
                     word_count <= IDX_W'(word);
                     word_idx   <= '0;
                     state      <= LOAD_WORD;
                  end
               end
            end

            LOAD_WORD: begin
               if (word_done) begin
                  o_write_instruction_mem <= 1'b1;
                  o_instruction_mem_addr  <= ADDR_W'(word_idx) << 2;
                  o_instruction_mem_data  <= word;
                  state                   <= WRITE;
               end
            end

            WRITE: begin
               word_idx <= next_idx;
               if (next_idx == word_count) begin
                  o_tx_data  <= ACK;
                  o_tx_valid <= 1'b1;
                  state      <= RESP;
               end else begin
                  state <= LOAD_WORD;
               end
            end

            RUN: begin
               // A simultaneous HALT byte and program end form one end event.
               if (i_program_end || (i_rx_valid && (i_rx_data == CMD_HALT))) begin
                  o_halt     <= 1'b1;
                  o_tx_data  <= ACK;
                  o_tx_valid <= 1'b1;
                  state      <= RESP;
               end
            end

            STEP: begin
               o_halt     <= 1'b1;
               o_tx_data  <= ACK;
               o_tx_valid <= 1'b1;
               state      <= RESP;
            end

            RESP: begin
               if (i_tx_ready) begin
                  o_tx_valid <= 1'b0;
                  state      <= IDLE;
               end
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_program_loader.sv
// -----------------------------------------------------------------------------
// tb_program_loader
// Self-checking bench for program_loader: directed scenarios plus a randomized
// command mix, checked against a command-level model of the loader.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_program_loader;
   import program_loader_pkg::*;

   localparam int MEM_DEPTH = 256;
   localparam int ADDR_W    = 32;

   // ---------------- clock / reset ----------------
   logic              i_clk = 1'b0;
   logic              i_reset;
   logic [7:0]        i_rx_data;
   logic              i_rx_valid;
   logic              i_tx_ready;
   logic              i_program_end;
   logic [7:0]        o_tx_data;
   logic              o_tx_valid;
   logic              o_write_instruction_mem;
   logic [ADDR_W-1:0] o_instruction_mem_addr;
   logic [31:0]       o_instruction_mem_data;
   logic              o_halt;
   logic              o_rx_overrun;
   state_t            dbg_state;

   always #5 i_clk = ~i_clk;

   program_loader #(.MEM_DEPTH(MEM_DEPTH), .ADDR_W(ADDR_W)) dut (
      .i_clk                   (i_clk),
      .i_reset                 (i_reset),
      .i_rx_data               (i_rx_data),
      .i_rx_valid              (i_rx_valid),
      .i_tx_ready              (i_tx_ready),
      .i_program_end           (i_program_end),
      .o_tx_data               (o_tx_data),
      .o_tx_valid              (o_tx_valid),
      .o_write_instruction_mem (o_write_instruction_mem),
      .o_instruction_mem_addr  (o_instruction_mem_addr),
      .o_instruction_mem_data  (o_instruction_mem_data),
      .o_halt                  (o_halt),
      .o_rx_overrun            (o_rx_overrun),
      .dbg_state               (dbg_state)
   );

   // ---------------- scoreboard ----------------
   int          checks = 0;
   int          errors = 0;
   logic [63:0] exp_q[$];        // expected writes: {byte address, data}
   logic [63:0] wr_exp;
   logic [31:0] load_words[$];   // words the next load sends

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // Every write strobe must match the next expected write, with the pipeline halted.
   always @(negedge i_clk) begin
      if (o_write_instruction_mem === 1'b1) begin
         if (exp_q.size() == 0) begin
            check("wr_unexpected", 64'd1, 64'd0);
         end else begin
            wr_exp = exp_q.pop_front();
            check("wr_addr", 64'(o_instruction_mem_addr), {32'd0, wr_exp[63:32]});
            check("wr_data", 64'(o_instruction_mem_data), {32'd0, wr_exp[31:0]});
            check("wr_halt", 64'(o_halt), 64'd1);
         end
      end
   end

   // ---------------- driver tasks ----------------
   task automatic send_byte(input logic [7:0] b, input int gap);
      @(posedge i_clk); #1;
      i_rx_data  = b;
      i_rx_valid = 1'b1;
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
      for (int g = 0; g < gap; g++) begin
         @(posedge i_clk); #1;
      end
   endtask

   // Waits for a reply, optionally stalling the transmitter first, and checks it.
   task automatic wait_reply(input string tag, input logic [7:0] exp, input int stall);
      bit seen = 1'b0;
      int st   = stall;
      for (int n = 0; n < 400 && !seen; n++) begin
         @(negedge i_clk);
         if (o_tx_valid === 1'b1) begin
            if (st > 0) begin
               check({tag, "_stall_data"}, 64'(o_tx_data), 64'(exp));
               st--;
            end else begin
               i_tx_ready = 1'b1;   // handshake on the coming edge
               check(tag, 64'(o_tx_data), 64'(exp));
               seen = 1'b1;
            end
         end
      end
      if (!seen) check({tag, "_timeout"}, 64'd0, 64'd1);
      @(posedge i_clk); #1;
      i_tx_ready = 1'b0;
   endtask

   // Model: a count of 0 is acknowledged, a count above capacity is refused,
   // otherwise word i lands at byte address 4*i and the load is acknowledged.
   task automatic do_load(input logic [31:0] n, input int gap_max, input int stall);
      logic [7:0]  rep;
      logic [31:0] w;
      send_byte(CMD_LOAD, $urandom_range(0, gap_max));
      for (int b = 3; b >= 0; b--) send_byte(n[8*b +: 8], $urandom_range(0, gap_max));
      if (n == 32'd0) begin
         rep = ACK;
      end else if (n > 32'(MEM_DEPTH)) begin
         rep = NAK;
      end else begin
         rep = ACK;
         for (int i = 0; i < int'(n); i++) begin
            w = load_words[i];
            exp_q.push_back({32'(i * 4), w});
            for (int b = 3; b >= 0; b--) send_byte(w[8*b +: 8], $urandom_range(0, gap_max));
         end
      end
      wait_reply("load_reply", rep, stall);
   endtask

   task automatic fill_words(input int n);
      load_words.delete();
      for (int i = 0; i < n; i++) load_words.push_back($urandom);
   endtask

   // end_mode: 0 = program end, 1 = 'H' byte, 2 = both in the same cycle
   task automatic do_run(input int cycles, input int end_mode);
      logic [7:0] junk;
      send_byte(CMD_RUN, 0);
      for (int c = 0; c < cycles; c++) begin
         @(negedge i_clk);
         check("run_halt_low", 64'(o_halt), 64'd0);
         @(posedge i_clk); #1;
         if ($urandom_range(0, 3) == 0) begin
            do junk = 8'($urandom_range(0, 255)); while (junk == CMD_HALT);
            i_rx_data  = junk;
            i_rx_valid = 1'b1;
         end else begin
            i_rx_valid = 1'b0;
         end
      end
      i_rx_valid = (end_mode != 0);
      i_rx_data  = CMD_HALT;
      i_program_end = (end_mode != 1);
      @(posedge i_clk); #1;
      i_rx_valid = 1'b0;
      @(negedge i_clk);
      check("run_halt_end", 64'(o_halt), 64'd1);
      wait_reply("run_ack", ACK, $urandom_range(0, 2));
      i_program_end = 1'b0;
      repeat (4) @(negedge i_clk);
      check("run_no_dup_ack", 64'(o_tx_valid), 64'd0);
      check("run_no_overrun", 64'(o_rx_overrun), 64'd0);
   endtask

   // Counts cycles with o_halt=0 between the 'S' byte and its ACK.
   task automatic do_step(input bit at_end);
      int  low  = 0;
      bit  seen = 1'b0;
      i_program_end = at_end;
      send_byte(CMD_STEP, 0);
      for (int n = 0; n < 50 && !seen; n++) begin
         @(negedge i_clk);
         if (o_halt === 1'b0) low++;
         if (o_tx_valid === 1'b1) begin
            i_tx_ready = 1'b1;
            check("step_ack", 64'(o_tx_data), 64'(ACK));
            seen = 1'b1;
         end
      end
      if (!seen) check("step_ack_timeout", 64'd0, 64'd1);
      check("step_pulse_len", 64'(low), at_end ? 64'd0 : 64'd1);
      @(posedge i_clk); #1;
      i_tx_ready    = 1'b0;
      i_program_end = 1'b0;
   endtask

   task automatic check_reset_values(input string tag);
      check({tag, "_state"}, 64'(dbg_state), 64'(IDLE));
      check({tag, "_halt"}, 64'(o_halt), 64'd1);
      check({tag, "_tx_valid"}, 64'(o_tx_valid), 64'd0);
      check({tag, "_tx_data"}, 64'(o_tx_data), 64'd0);
      check({tag, "_we"}, 64'(o_write_instruction_mem), 64'd0);
      check({tag, "_addr"}, 64'(o_instruction_mem_addr), 64'd0);
      check({tag, "_data"}, 64'(o_instruction_mem_data), 64'd0);
      check({tag, "_overrun"}, 64'(o_rx_overrun), 64'd0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #3_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- stimulus ----------------
   initial begin
      logic [7:0] bad;
      bit         seen;
      i_reset       = 1'b0;
      i_rx_data     = 8'd0;
      i_rx_valid    = 1'b0;
      i_tx_ready    = 1'b0;
      i_program_end = 1'b0;
      repeat (3) @(posedge i_clk);
      @(negedge i_clk);
      check_reset_values("reset");
      @(posedge i_clk); #1;
      i_reset = 1'b1;

      // Directed two-word load
      load_words = '{32'h2008_0005, 32'h0109_5020};
      do_load(32'd2, 1, 0);
      check("load_halt_after", 64'(o_halt), 64'd1);

      // Count boundaries
      do_load(32'd257, 1, 0);
      @(negedge i_clk);
      check("oversize_idle", 64'(dbg_state), 64'(IDLE));
      do_load(32'd0, 1, 1);

      // Run ended by program end, by 'H', and by both together
      do_run(20, 0);
      do_run(20, 1);
      do_run(5, 2);

      // Single steps
      repeat (3) do_step(1'b0);
      do_step(1'b1);

      // Full-capacity load
      fill_words(MEM_DEPTH);
      do_load(32'(MEM_DEPTH), 0, 0);

      // Randomized command mix
      for (int k = 0; k < 30; k++) begin
         case ($urandom_range(0, 5))
            0: begin
               fill_words(6);
               do_load(32'($urandom_range(0, 6)), 2, $urandom_range(0, 3));
            end
            1: do_load(32'(MEM_DEPTH + 1) + $urandom_range(0, 5000), 2, 0);
            2: do_run($urandom_range(1, 30), $urandom_range(0, 2));
            3: do_step($urandom_range(0, 3) == 0);
            4: begin
               send_byte(CMD_HALT, $urandom_range(0, 2));
               wait_reply("halt_ack", ACK, $urandom_range(0, 3));
               check("halt_level", 64'(o_halt), 64'd1);
            end
            default: begin
               do bad = 8'($urandom_range(0, 255));
               while (bad == CMD_LOAD || bad == CMD_RUN || bad == CMD_STEP || bad == CMD_HALT);
               send_byte(bad, $urandom_range(0, 2));
               wait_reply("bad_cmd_nak", NAK, $urandom_range(0, 3));
            end
         endcase
      end
      check("overrun_clear", 64'(o_rx_overrun), 64'd0);

      // Back-pressure: reply held through a stall; a byte sent meanwhile is dropped
      send_byte(CMD_HALT, 0);
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
         @(negedge i_clk);
         if (o_tx_valid === 1'b1) seen = 1'b1;
      end
      check("bp_valid_up", 64'(seen), 64'd1);
      for (int c = 0; c < 10; c++) begin
         @(negedge i_clk);
         check("bp_valid_held", 64'(o_tx_valid), 64'd1);
         check("bp_data_held", 64'(o_tx_data), 64'(ACK));
         if (c == 3) begin
            @(posedge i_clk); #1;
            i_rx_data  = CMD_LOAD;
            i_rx_valid = 1'b1;
            @(posedge i_clk); #1;
            i_rx_valid = 1'b0;
         end
      end
      check("bp_overrun", 64'(o_rx_overrun), 64'd1);
      wait_reply("bp_ack", ACK, 0);
      // If the dropped 'L' had been taken, this 'H' would be a count byte.
      send_byte(CMD_HALT, 0);
      wait_reply("bp_after_ack", ACK, 0);

      // Reset in the middle of a three-word load, after two words
      fill_words(3);
      send_byte(CMD_LOAD, 0);
      for (int b = 3; b >= 0; b--) send_byte((b == 0) ? 8'd3 : 8'd0, 0);
      for (int i = 0; i < 2; i++) begin
         exp_q.push_back({32'(i * 4), load_words[i]});
         for (int b = 3; b >= 0; b--) send_byte(load_words[i][8*b +: 8], 1);
      end
      repeat (3) @(posedge i_clk);
      #1;
      i_reset = 1'b0;
      @(posedge i_clk);
      @(negedge i_clk);
      check_reset_values("midload_reset");
      check("midload_writes_done", 64'(exp_q.size()), 64'd0);
      @(posedge i_clk); #1;
      i_reset = 1'b1;
      send_byte(CMD_HALT, 0);
      wait_reply("post_reset_ack", ACK, 0);

      repeat (5) @(negedge i_clk);
      check("writes_all_seen", 64'(exp_q.size()), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
